rs232_host_link: RTL and testbench

//  Host-side serial front end for the RS232 memory. Sits directly upstream/downstream of it.

---
 rtl/rs232_host_link_pkg.sv | 30 +++
 rtl/rs232_host_link_if.sv | 32 +++
 rtl/rs232_host_fifo.sv | 61 ++++++
 rtl/rs232_host_link.sv | 222 ++++++++++++++++++++++
 tb/tb_rs232_host_link.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs232_host_link_pkg.sv
// Shared definitions for the RS232 host link: FSM state encodings, frame constants
// and the parity helper used by both the transmit and receive paths.
package rs232_host_link_pkg;

  typedef enum logic [2:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_PAR,
    T_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_PAR,
    R_STOP
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // odd = 1 makes the total number of ones (data + parity) odd.
  function automatic logic par_bit(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/rs232_host_link_if.sv
// Host-facing command/response bundle of the RS232 host link.
interface rs232_host_link_if;

  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output cmd_data,
    output cmd_valid,
    input  cmd_ready,
    input  rsp_data,
    input  rsp_valid,
    input  parity_err,
    input  frame_err
  );

  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready,
    output rsp_data,
    output rsp_valid,
    output parity_err,
    output frame_err
  );

endinterface

// File: rtl/rs232_host_fifo.sv
// Small synchronous FIFO for the command path; full/empty are registered flags.
module rs232_host_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Flags are derived from the next count so they are registered yet never lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rs232_host_link.sv
// Full-duplex RS232 host front end: FIFO-fed serializer and 2-flop-synced deserializer.
// Define RS232_HOST_PARITY_CHK_EN to report received parity mismatches on parity_err.
module rs232_host_link
  import rs232_host_link_pkg::*;
#(
  parameter logic [19:0] RS232_RATIO = 20'd1736,
  parameter logic        PARITY      = 1'b1,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  rs232_host_link_if.slave host,
  output logic             tx_busy,
  output logic             ser_out,
  input  logic             ser_in
);

  localparam logic [19:0] BIT_LAST = RS232_RATIO - 20'd1;
  localparam logic [19:0] HALF_BIT = RS232_RATIO >> 1;
  localparam logic [2:0]  LAST_IDX = 3'(DATA_BITS - 1);

  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;

  rs232_host_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (host.cmd_data),
    .push    (host.cmd_valid),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign host.cmd_ready = ~fifo_full;

  tx_state_t   tx_state, tx_next;
  logic [19:0] tx_cnt, tx_cnt_next;
  logic [7:0]  tx_shift, tx_shift_next;
  logic [2:0]  tx_idx, tx_idx_next;
  logic        tx_par, tx_par_next;
  logic        ser_out_next;

  assign tx_busy = (tx_state != T_IDLE) | ~fifo_empty;

  // ser_out is registered from the upcoming state, so the line level changes on the same edge as the state.
  always_comb begin
    tx_next       = tx_state;
    tx_cnt_next   = tx_cnt;
    tx_shift_next = tx_shift;
    tx_idx_next   = tx_idx;
    tx_par_next   = tx_par;
    fifo_pop      = 1'b0;
    ser_out_next  = STOP_BIT;
    if (tx_state != T_IDLE) tx_cnt_next = tx_cnt - 20'd1;
    case (tx_state)
      T_IDLE: if (!fifo_empty) begin
        fifo_pop      = 1'b1;
        tx_shift_next = fifo_head;
        tx_par_next   = par_bit(fifo_head, PARITY);
        tx_cnt_next   = BIT_LAST;
        tx_next       = T_START;
      end
      T_START: if (tx_cnt == '0) begin
        tx_cnt_next = BIT_LAST;
        tx_idx_next = '0;
        tx_next     = T_DATA;
      end
      T_DATA: if (tx_cnt == '0) begin
        tx_cnt_next   = BIT_LAST;
        tx_shift_next = tx_shift >> 1;
        if (tx_idx == LAST_IDX) tx_next = T_PAR;
        else                    tx_idx_next = tx_idx + 3'd1;
      end
      T_PAR: if (tx_cnt == '0) begin
        tx_cnt_next = BIT_LAST;
        tx_next     = T_STOP;
      end
      T_STOP: if (tx_cnt == '0) begin
        tx_cnt_next = '0;
        tx_next     = T_IDLE;
      end
      default: tx_next = T_IDLE;
    endcase
    case (tx_next)
      T_START: ser_out_next = START_BIT;
      T_DATA:  ser_out_next = tx_shift_next[0];
      T_PAR:   ser_out_next = tx_par_next;
      default: ser_out_next = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_idx   <= '0;
      tx_par   <= 1'b0;
      ser_out  <= STOP_BIT;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= tx_cnt_next;
      tx_shift <= tx_shift_next;
      tx_idx   <= tx_idx_next;
      tx_par   <= tx_par_next;
      ser_out  <= ser_out_next;
    end
  end

  logic [1:0]  rx_sync;
  logic        rx_bit;
  rx_state_t   rx_state, rx_next;
  logic [19:0] rx_cnt, rx_cnt_next;
  logic [7:0]  rx_shift, rx_shift_next;
  logic [2:0]  rx_idx, rx_idx_next;
  logic [7:0]  rsp_data_next;
  logic        rsp_valid_next;
  logic        parity_err_next;
  logic        frame_err_next;
`ifdef RS232_HOST_PARITY_CHK_EN
  logic        rx_par, rx_par_next;
`endif

  assign rx_bit = rx_sync[1];

  // Start detection loads half a bit so every later sample lands near the bit centre.
  always_comb begin
    rx_next         = rx_state;
    rx_cnt_next     = rx_cnt;
    rx_shift_next   = rx_shift;
    rx_idx_next     = rx_idx;
    rsp_data_next   = host.rsp_data;
    rsp_valid_next  = 1'b0;
    parity_err_next = 1'b0;
    frame_err_next  = 1'b0;
`ifdef RS232_HOST_PARITY_CHK_EN
    rx_par_next     = rx_par;
`endif
    if (rx_state != R_IDLE) rx_cnt_next = rx_cnt - 20'd1;
    case (rx_state)
      R_IDLE: if (rx_bit == START_BIT) begin
        rx_cnt_next = HALF_BIT;
        rx_next     = R_START;
      end
      R_START: if (rx_cnt == '0) begin
        if (rx_bit != START_BIT) begin
          rx_cnt_next = '0;
          rx_next     = R_IDLE;
        end else begin
          rx_cnt_next = BIT_LAST;
          rx_idx_next = '0;
          rx_next     = R_DATA;
        end
      end
      R_DATA: if (rx_cnt == '0) begin
        rx_cnt_next   = BIT_LAST;
        rx_shift_next = {rx_bit, rx_shift[7:1]};
        if (rx_idx == LAST_IDX) rx_next = R_PAR;
        else                    rx_idx_next = rx_idx + 3'd1;
      end
      R_PAR: if (rx_cnt == '0) begin
`ifdef RS232_HOST_PARITY_CHK_EN
        rx_par_next = rx_bit;
`endif
        rx_cnt_next = BIT_LAST;
        rx_next     = R_STOP;
      end
      R_STOP: if (rx_cnt == '0) begin
        rx_cnt_next = '0;
        rx_next     = R_IDLE;
        if (rx_bit == STOP_BIT) begin
          rsp_valid_next = 1'b1;
          rsp_data_next  = rx_shift;
`ifdef RS232_HOST_PARITY_CHK_EN
          parity_err_next = (rx_par != par_bit(rx_shift, PARITY));
`endif
        end else begin
          frame_err_next = 1'b1;
        end
      end
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync         <= 2'b11;
      rx_state        <= R_IDLE;
      rx_cnt          <= '0;
      rx_shift        <= '0;
      rx_idx          <= '0;
      host.rsp_data   <= '0;
      host.rsp_valid  <= 1'b0;
      host.parity_err <= 1'b0;
      host.frame_err  <= 1'b0;
`ifdef RS232_HOST_PARITY_CHK_EN
      rx_par          <= 1'b0;
`endif
    end else begin
      rx_sync         <= {rx_sync[0], ser_in};
      rx_state        <= rx_next;
      rx_cnt          <= rx_cnt_next;
      rx_shift        <= rx_shift_next;
      rx_idx          <= rx_idx_next;
      host.rsp_data   <= rsp_data_next;
      host.rsp_valid  <= rsp_valid_next;
      host.parity_err <= parity_err_next;
      host.frame_err  <= frame_err_next;
`ifdef RS232_HOST_PARITY_CHK_EN
      rx_par          <= rx_par_next;
`endif
    end
  end

endmodule

// File: tb/tb_rs232_host_link.sv
// Scoreboard bench for rs232_host_link: expected frames and strobes are queued at stimulus time
// and checked by independent TX/RX monitors against a bit-level model of the frame format.
module tb_rs232_host_link;

  localparam logic [19:0] RATIO  = 20'd16;
  localparam int          BITW   = 16;
  localparam int          FRAME  = 11 * BITW;
  localparam logic        PODD   = 1'b1;
  localparam int          DEPTH  = 4;
`ifdef RS232_HOST_PARITY_CHK_EN
  localparam logic        PCHK   = 1'b1;
`else
  localparam logic        PCHK   = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    int         acc;
    int         start;
  } tx_item_t;

  typedef struct {
    logic       is_rsp;
    logic [7:0] data;
    logic       perr;
  } rx_item_t;

  logic clk = 1'b0;
  logic rst;
  logic tx_busy;
  logic ser_out;
  logic ser_in;

  rs232_host_link_if host();

  rs232_host_link #(
    .RS232_RATIO (RATIO),
    .PARITY      (PODD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .host    (host),
    .tx_busy (tx_busy),
    .ser_out (ser_out),
    .ser_in  (ser_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  tx_item_t   tx_exp[$];
  int         tx_starts[$];
  int         last_start = -1000;
  rx_item_t   rx_exp[$];
  logic [7:0] last_rsp = 8'h00;
  logic       rx_abort = 1'b0;
  logic       saw_not_ready = 1'b0;

  // Parity bit that makes the ones count odd (PODD=1) or even (PODD=0).
  function automatic logic model_par(input logic [7:0] d);
    int ones;
    ones = $countones(d);
    return PODD ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one command byte; the accept cycle predicts the exact start of its frame.
  task automatic apply_stimulus(input logic [7:0] b);
    tx_item_t it;
    logic     taken;
    taken = 1'b0;
    host.cmd_data  = b;
    host.cmd_valid = 1'b1;
    for (int w = 0; w < 4000 && !taken; w++) begin
      @(negedge clk);
      while (tx_starts.size() > 0 && tx_starts[0] <= cyc) void'(tx_starts.pop_front());
      check_output("cmd_ready", host.cmd_ready, tx_starts.size() < DEPTH);
      if (!host.cmd_ready) saw_not_ready = 1'b1;
      if (host.cmd_ready) begin
        taken      = 1'b1;
        it.data    = b;
        it.acc     = cyc;
        it.start   = max2(cyc + 2, last_start + FRAME + 1);
        last_start = it.start;
        tx_exp.push_back(it);
        tx_starts.push_back(it.start);
      end
      @(posedge clk);
      #1;
    end
    if (!taken) check_output("cmd_accept_timeout", host.cmd_ready, 1);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    rx_item_t    it;
    bits      = {s, p, d, 1'b0};
    it.is_rsp = s;
    it.data   = d;
    it.perr   = PCHK && s && (p != model_par(d));
    rx_exp.push_back(it);
    for (int b = 0; b < 11 && !rx_abort; b++) begin
      for (int k = 0; k < BITW && !rx_abort; k++) begin
        ser_in = bits[b];
        @(posedge clk);
        #1;
      end
    end
    ser_in = 1'b1;
  endtask

  task automatic wait_tx_drain(input int limit);
    for (int i = 0; i < limit && (tx_exp.size() > 0 || tx_active); i++) idle(1);
    idle(3);
    check_output("tx_drain", tx_exp.size() + int'(tx_active), 0);
  endtask

  task automatic flush_model();
    tx_exp.delete();
    tx_starts.delete();
    rx_exp.delete();
    last_start = -1000;
    last_rsp   = 8'h00;
  endtask

  logic        tx_active = 1'b0;
  logic        tx_busy_chk = 1'b0;
  logic        tx_pend;
  int          tx_idx;
  int          tx_bad;
  tx_item_t    tx_cur;
  logic [10:0] tx_bits;

  // TX monitor: every frame is compared clock by clock against its predicted waveform.
  always @(negedge clk) begin
    if (rst) begin
      tx_active   = 1'b0;
      tx_busy_chk = 1'b0;
    end else begin
      if (tx_busy_chk) begin
        tx_pend = 1'b0;
        foreach (tx_exp[i]) if (tx_exp[i].acc < cyc) tx_pend = 1'b1;
        check_output("tx_busy_after_stop", tx_busy, tx_pend);
        tx_busy_chk = 1'b0;
      end
      if (!tx_active && ser_out == 1'b0) begin
        if (tx_exp.size() == 0) begin
          check_output("tx_idle_line", ser_out, 1);
        end else begin
          tx_cur    = tx_exp.pop_front();
          check_output("tx_start_cycle", cyc, tx_cur.start);
          tx_bits   = {1'b1, model_par(tx_cur.data), tx_cur.data, 1'b0};
          tx_active = 1'b1;
          tx_idx    = 0;
          tx_bad    = 0;
        end
      end
      if (tx_active) begin
        if (ser_out !== tx_bits[tx_idx / BITW]) tx_bad++;
        tx_idx++;
        if (tx_idx == FRAME) begin
          if (tx_bad != 0) $display("[TB] frame for byte 0x%0h had %0d wrong clocks", tx_cur.data, tx_bad);
          check_output("tx_frame_bits", tx_bad, 0);
          tx_active   = 1'b0;
          tx_busy_chk = 1'b1;
        end
      end
    end
  end

  rx_item_t rx_cur;

  // RX monitor: any strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (host.rsp_valid || host.frame_err || host.parity_err)) begin
      if (rx_exp.size() == 0) begin
        check_output("rx_unexpected_strobe", {host.rsp_valid, host.frame_err, host.parity_err}, 0);
      end else begin
        rx_cur = rx_exp.pop_front();
        check_output("rx_rsp_valid", host.rsp_valid, rx_cur.is_rsp);
        check_output("rx_frame_err", host.frame_err, !rx_cur.is_rsp);
        check_output("rx_parity_err", host.parity_err, rx_cur.perr);
        if (rx_cur.is_rsp) begin
          check_output("rx_rsp_data", host.rsp_data, rx_cur.data);
          last_rsp = rx_cur.data;
        end else begin
          check_output("rx_data_held", host.rsp_data, last_rsp);
        end
      end
    end
  end

  initial begin
    #700000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;
    int         gap;

    rst            = 1'b1;
    ser_in         = 1'b1;
    host.cmd_valid = 1'b0;
    host.cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_output("reset_ser_out", ser_out, 1);
    check_output("reset_cmd_ready", host.cmd_ready, 1);
    check_output("reset_tx_busy", tx_busy, 0);
    check_output("reset_rsp_valid", host.rsp_valid, 0);
    check_output("reset_rsp_data", host.rsp_data, 0);
    check_output("reset_errs", {host.parity_err, host.frame_err}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    $display("[TB] single byte 0xA5");
    apply_stimulus(8'hA5);
    host.cmd_valid = 1'b0;
    wait_tx_drain(1000);

    $display("[TB] burst 0x01..0x06");
    saw_not_ready = 1'b0;
    for (int i = 1; i <= 6; i++) apply_stimulus(8'(i));
    host.cmd_valid = 1'b0;
    check_output("cmd_ready_dropped", saw_not_ready, 1);
    wait_tx_drain(3000);

    $display("[TB] receive frames");
    drive_frame(8'h3C, model_par(8'h3C), 1'b1);
    idle(12);
    check_output("rx_drain_good", rx_exp.size(), 0);
    drive_frame(8'h3C, ~model_par(8'h3C), 1'b1);
    idle(12);
    check_output("rx_drain_badpar", rx_exp.size(), 0);
    ser_in = 1'b0;
    idle(3);
    ser_in = 1'b1;
    idle(30);
    drive_frame(8'h55, model_par(8'h55), 1'b0);
    idle(12);
    check_output("rx_drain_framing", rx_exp.size(), 0);

    $display("[TB] reset in mid-frame");
    fork
      drive_frame(8'hC3, model_par(8'hC3), 1'b1);
      begin
        idle(28);
        apply_stimulus(8'h5A);
        apply_stimulus(8'h11);
        host.cmd_valid = 1'b0;
      end
      begin
        repeat (100) @(posedge clk);
        #3;
        rst      = 1'b1;
        rx_abort = 1'b1;
        #1;
        check_output("rst_ser_out_async", ser_out, 1);
        flush_model();
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        rx_abort = 1'b0;
      end
    join
    @(negedge clk);
    check_output("post_rst_cmd_ready", host.cmd_ready, 1);
    check_output("post_rst_tx_busy", tx_busy, 0);
    idle(1);
    apply_stimulus(8'h7E);
    host.cmd_valid = 1'b0;
    wait_tx_drain(1000);
    check_output("post_rst_rx_quiet", rx_exp.size(), 0);

    $display("[TB] random full-duplex traffic");
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          gap = $urandom_range(0, 150);
          if (gap > 0) begin
            host.cmd_valid = 1'b0;
            idle(gap);
          end
          apply_stimulus(8'($urandom));
        end
        host.cmd_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          d = 8'($urandom);
          p = ($urandom_range(0, 3) == 0) ? ~model_par(d) : model_par(d);
          s = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
          drive_frame(d, p, s);
          idle(12 + $urandom_range(0, 20));
          check_output("rx_drain_random", rx_exp.size(), 0);
        end
      end
    join
    wait_tx_drain(4000);
    check_output("final_tx_busy", tx_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
